// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter.
// Provides the operand width, digit geometry, iteration count and the
// control FSM state encoding used by binary_to_bcd_converter.
package bcd_pkg;

   localparam int unsigned BIN_W   = 8;
   localparam int unsigned DIGITS  = 3;
   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned SCR_W   = DIGITS * DIGIT_W;
   localparam int unsigned OUT_W   = 2 * DIGIT_W;
   localparam int unsigned ITER    = 8;
   localparam int unsigned CNT_W   = $clog2(ITER);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage : bcd_pkg

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
// Ports:
//   digit_i : current BCD digit
//   adj_c   : corrected digit (combinational)
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [DIGIT_W-1:0] adj_c
);

   always_comb begin
      adj_c = digit_i;
      if (digit_i >= DIGIT_W'(5)) begin
         adj_c = digit_i + DIGIT_W'(3);
      end
   end

endmodule : bcd_add3

// File: rtl/binary_to_bcd_converter.sv
// Sequential 8-bit binary to two-digit packed BCD converter (double-dabble).
// A start seen in IDLE latches the operand; eight SHIFT iterations build a
// hundreds/tens/units scratch value, which is published on entry to DONE.
// Ports:
//   clk            : clock, rising edge
//   rst            : asynchronous active-high reset
//   start          : conversion request, sampled only in IDLE
//   binary_number  : unsigned operand 0..255
//   busy           : high while not IDLE
//   done           : one-cycle pulse, new result valid
//   decimal_number : {tens, units} packed BCD
//   overflow       : operand of the last result exceeded 99
// Build option: define BCD_SATURATE_EN to report overflowing results as 8'h99
// instead of the low two decimal digits.
module binary_to_bcd_converter
   import bcd_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [BIN_W-1:0] binary_number,
   output logic             busy,
   output logic             done,
   output logic [OUT_W-1:0] decimal_number,
   output logic             overflow
);

   state_e             state_q, state_d;
   logic [BIN_W-1:0]   op_q,    op_d;
   logic [SCR_W-1:0]   scr_q,   scr_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic               last_q,  last_d;
   logic               busy_q,  busy_d;
   logic               done_q,  done_d;
   logic [OUT_W-1:0]   dec_q,   dec_d;
   logic               ovf_q,   ovf_d;

   logic [SCR_W-1:0]   adj_c;
   logic [DIGIT_W-1:0] hund_c;
   logic               unused_adj_msb_c;

   // Per-digit "+3 if >=5" correction ahead of each shift.
   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .digit_i (scr_q[g*DIGIT_W +: DIGIT_W]),
         .adj_c   (adj_c[g*DIGIT_W +: DIGIT_W])
      );
   end

   assign hund_c = scr_q[SCR_W-1 -: DIGIT_W];
   // The hundreds digit never exceeds 2 for an 8-bit operand, so its MSB is
   // always shifted out as zero.
   assign unused_adj_msb_c = adj_c[SCR_W-1];

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dec_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dec_q   <= dec_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      scr_d   = scr_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      dec_d   = dec_q;
      ovf_d   = ovf_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d    = binary_number;
               scr_d   = '0;
               cnt_d   = '0;
               last_d  = 1'b0;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (!last_q) begin
               scr_d = {adj_c[SCR_W-2:0], op_q[BIN_W-1]};
               op_d  = {op_q[BIN_W-2:0], 1'b0};
               cnt_d = cnt_q + CNT_W'(1);
               // Eighth shift in progress; the following cycle publishes.
               if (cnt_q == CNT_W'(ITER - 1)) begin
                  last_d = 1'b1;
               end
            end else begin
               state_d = ST_DONE;
               ovf_d   = (hund_c != '0);
`ifdef BCD_SATURATE_EN
               dec_d   = (hund_c != '0) ? OUT_W'(8'h99) : scr_q[OUT_W-1:0];
`else
               dec_d   = scr_q[OUT_W-1:0];
`endif
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign decimal_number = dec_q;
   assign overflow       = ovf_q;

endmodule : binary_to_bcd_converter

// File: tb/tb_binary_to_bcd_converter.sv
// Directed bench for binary_to_bcd_converter with a result scoreboard.
module tb_binary_to_bcd_converter;

   typedef struct packed {
      logic [7:0] dec;
      logic       ovf;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] binary_number;
   logic       busy;
   logic       done;
   logic [7:0] decimal_number;
   logic       overflow;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   binary_to_bcd_converter dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .binary_number  (binary_number),
      .busy           (busy),
      .done           (done),
      .decimal_number (decimal_number),
      .overflow       (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic [7:0] v);
      exp_t        e;
      int unsigned r;
      r     = int'(v) % 100;
      e.ovf = (v > 8'd99);
      e.dec = {4'(r / 10), 4'(r % 10)};
`ifdef BCD_SATURATE_EN
      if (e.ovf) e.dec = 8'h99;
`endif
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns edges elapsed until done is seen, or -1 after 20 edges.
   task automatic wait_done(output int k);
      k = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (done === 1'b1) begin
            k = i;
            break;
         end
      end
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      check({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check({tag, "_dec"}, 32'(decimal_number), 32'(e.dec));
         check({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
      end
   endtask

   // One full conversion, started from a point just after a clock edge.
   task automatic run_conv(input logic [7:0] v, input string tag);
      int k;
      start         = 1'b1;
      binary_number = v;
      sb_q.push_back(model(v));
      tick();
      start         = 1'b0;
      binary_number = 8'($urandom);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      wait_done(k);
      check({tag, "_latency"}, 32'(k), 32'd9);
      check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
      pop_check(tag);
      tick();
      check({tag, "_done_low"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int k;
      int pulses;
      int first;

      rst           = 1'b1;
      start         = 1'b0;
      binary_number = 8'd0;
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_dec", 32'(decimal_number), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      tick();
      rst = 1'b0;

      run_conv(8'd47, "c47");
      run_conv(8'd0, "c0");
      run_conv(8'd99, "c99");
      run_conv(8'd255, "c255");
      run_conv(8'd123, "c123");
      run_conv(8'd100, "c100");

      // Second start mid-conversion must be ignored.
      start         = 1'b1;
      binary_number = 8'd63;
      sb_q.push_back(model(8'd63));
      tick();
      start = 1'b0;
      repeat (3) tick();
      start         = 1'b1;
      binary_number = 8'd12;
      tick();
      start  = 1'b0;
      pulses = 0;
      first  = -1;
      for (int i = 5; i <= 16; i++) begin
         tick();
         if (done === 1'b1) begin
            pulses++;
            if (first < 0) first = i;
         end
      end
      check("ign_first_done", 32'(first), 32'd9);
      check("ign_pulses", 32'(pulses), 32'd1);
      pop_check("ign");

      // Asynchronous reset in the middle of a conversion.
      start         = 1'b1;
      binary_number = 8'd88;
      sb_q.push_back(model(8'd88));
      tick();
      start = 1'b0;
      repeat (4) tick();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      sb_q.delete();
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_dec", 32'(decimal_number), 32'd0);
      check("abort_ovf", 32'(overflow), 32'd0);
      tick();
      check("abort_hold_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      run_conv(8'd88, "c88");

      // Start held high: back-to-back conversions with one idle cycle between.
      start         = 1'b1;
      binary_number = 8'd10;
      sb_q.push_back(model(8'd10));
      tick();
      for (int c = 0; c < 3; c++) begin
         check("held_busy", 32'(busy), 32'd1);
         wait_done(k);
         check("held_latency", 32'(k), 32'd9);
         pop_check("held");
         tick();
         check("held_gap", 32'(busy), 32'd0);
         if (c == 2) start = 1'b0;
         else sb_q.push_back(model(8'd10));
         tick();
      end
      check("held_stop", 32'(busy), 32'd0);
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_binary_to_bcd_converter
